// File: rtl/sramlike_axi_pkg.sv
// Shared definitions for the sram-like to AXI bridges: FSM states, access sizes,
// AXI response codes and the sram-like size to AXI AxSIZE mapping.
package sramlike_axi_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD_ADDR = 3'd1;
  localparam logic [2:0] ST_RD_DATA = 3'd2;
  localparam logic [2:0] ST_WR_REQ  = 3'd3;
  localparam logic [2:0] ST_WR_RESP = 3'd4;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // Size 3 has no wider meaning on a 32-bit bus, so it is issued as a word.
  function automatic logic [2:0] axi_size(input logic [1:0] size);
    return (size == 2'd3) ? {1'b0, SIZE_WORD} : {1'b0, size};
  endfunction

endpackage

// File: rtl/axi_wstrb_gen.sv
// Byte-strobe generator for a 32-bit AXI write: access size plus low address
// bits to a 4-bit lane mask. Purely combinational.
module axi_wstrb_gen
  import sramlike_axi_pkg::*;
(
  input  logic [1:0] size_i,
  input  logic [1:0] addr_lo_i,
  output logic [3:0] wstrb_o
);

  // Select the lanes covered by the access; half-words use addr[1] only.
  always_comb begin
    wstrb_o = 4'b1111;
    case (size_i)
      SIZE_BYTE: wstrb_o = 4'b0001 << addr_lo_i;
      SIZE_HALF: wstrb_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
      default:   wstrb_o = 4'b1111;
    endcase
  end

endmodule

// File: rtl/sramlike_axi_bridge.sv
// Data-side sram-like responder that turns each accepted request into one
// single-beat AXI read (AR/R) or write (AW/W/B). One transaction in flight.
// Optional response-error reporting: define SRAMLIKE_AXI_RESP_ERR_EN to add
// data_err and bus_err_sticky outputs.
module sramlike_axi_bridge
  import sramlike_axi_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [ADDR_W-1:0] araddr,
  output logic [2:0]        arsize,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic [ADDR_W-1:0] awaddr,
  output logic [2:0]        awsize,
  output logic              awvalid,
  input  logic              awready,
  output logic [DATA_W-1:0] wdata,
  output logic [3:0]        wstrb,
  output logic              wvalid,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready
`ifdef SRAMLIKE_AXI_RESP_ERR_EN
  ,
  output logic              data_err,
  output logic              bus_err_sticky
`endif
);

  logic [2:0]        state_q, state_d;
  logic              wr_q, wr_d;
  logic [1:0]        size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic              resp_err;

  // State and latched-request registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      wr_q      <= 1'b0;
      size_q    <= 2'b00;
      addr_q    <= '0;
      wdata_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_q      <= wr_d;
      size_q    <= size_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // Next-state and handshake outputs; request fields only move in IDLE.
  always_comb begin
    state_d      = state_q;
    wr_d         = wr_q;
    size_d       = size_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    arvalid      = 1'b0;
    rready       = 1'b0;
    awvalid      = 1'b0;
    wvalid       = 1'b0;
    bready       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        data_addr_ok = data_req;
        if (data_req) begin
          wr_d      = data_wr;
          size_d    = data_size;
          addr_d    = data_addr;
          wdata_d   = data_wdata;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = data_wr ? ST_WR_REQ : ST_RD_ADDR;
        end
      end
      ST_RD_ADDR: begin
        arvalid = 1'b1;
        if (arready) state_d = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        rready = 1'b1;
        if (rvalid) begin
          data_data_ok = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      ST_WR_REQ: begin
        awvalid   = ~aw_done_q;
        wvalid    = ~w_done_q;
        aw_done_d = aw_done_q | awready;
        w_done_d  = w_done_q | wready;
        if (aw_done_d && w_done_d) state_d = ST_WR_RESP;
      end
      ST_WR_RESP: begin
        bready = 1'b1;
        if (bvalid) begin
          data_data_ok = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered request fields drive both AXI address channels directly.
  assign araddr     = addr_q;
  assign awaddr     = addr_q;
  assign arsize     = axi_size(size_q);
  assign awsize     = axi_size(size_q);
  assign wdata      = wdata_q;
  assign data_rdata = rdata;

  axi_wstrb_gen u_wstrb (
    .size_i    (size_q),
    .addr_lo_i (addr_q[1:0]),
    .wstrb_o   (wstrb)
  );

  // Completing response is an error when it is anything but OKAY.
  assign resp_err = data_data_ok &
                    (wr_q ? (bresp != AXI_RESP_OKAY) : (rresp != AXI_RESP_OKAY));

`ifdef SRAMLIKE_AXI_RESP_ERR_EN
  logic err_seen_q;

  // Sticky record of any errored completion since reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_seen_q <= 1'b0;
    else     err_seen_q <= err_seen_q | resp_err;
  end

  assign data_err       = resp_err;
  assign bus_err_sticky = err_seen_q;
`else
  logic unused_resp_err;
  assign unused_resp_err = resp_err;
`endif

endmodule

// File: tb/tb_sramlike_axi_bridge.sv
// Self-checking bench for sramlike_axi_bridge: directed vectors from a table,
// random vectors scored against a byte-lane model, plus reset corner cases.
module tb_sramlike_axi_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [2:0]  arsize, awsize;
  logic        arvalid, arready, rvalid, rready;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [1:0]  rresp, bresp;
  logic [3:0]  wstrb;
`ifdef SRAMLIKE_AXI_RESP_ERR_EN
  logic        data_err, bus_err_sticky;
`endif

  sramlike_axi_bridge dut (
    .clk(clk), .rst(rst),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
`ifdef SRAMLIKE_AXI_RESP_ERR_EN
    , .data_err(data_err), .bus_err_sticky(bus_err_sticky)
`endif
  );

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [1:0]  resp;
    int          d_a;     // cycles before arready/awready
    int          d_w;     // cycles before wready
    int          d_r;     // cycles before rvalid/bvalid
    logic        hold;    // keep data_req high while busy
    logic [3:0]  exp_strb;
    logic [2:0]  exp_axsize;
  } vec_t;

  int   checks   = 0;
  int   failures = 0;
  logic sticky_m = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s timeout t=%0t", name, $time);
  endtask

  // Lanes touched by an access: naturally aligned block of 1/2/4 bytes.
  function automatic logic [3:0] model_strb(input logic [1:0] size, input logic [31:0] addr);
    int lane   = int'(addr % 4);
    int nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    int first  = lane - (lane % nbytes);
    logic [3:0] m = 4'b0000;
    for (int b = 0; b < 4; b++)
      if (b >= first && b < first + nbytes) m[b] = 1'b1;
    return m;
  endfunction

  function automatic logic [2:0] model_axsize(input logic [1:0] size);
    return (size == 2'd3) ? 3'd2 : {1'b0, size};
  endfunction

  function automatic vec_t mk(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [31:0] rd, input logic [1:0] resp,
                              input int d_a, input int d_w, input int d_r, input logic hold,
                              input logic [3:0] strb, input logic [2:0] axsize);
    vec_t v;
    v.wr = wr; v.size = size; v.addr = addr; v.wdata = wd; v.rdata = rd; v.resp = resp;
    v.d_a = d_a; v.d_w = d_w; v.d_r = d_r; v.hold = hold;
    v.exp_strb = strb; v.exp_axsize = axsize;
    return v;
  endfunction

  task automatic axi_quiet();
    arready = 1'b0; awready = 1'b0; wready = 1'b0;
    rvalid = 1'b0; bvalid = 1'b0; rresp = 2'b00; bresp = 2'b00;
    rdata = $urandom;
  endtask

  // Scramble the request fields while busy; the bridge must ignore them.
  task automatic busy_inputs(input logic hold);
    data_req   = hold;
    data_wr    = 1'($urandom);
    data_size  = 2'($urandom);
    data_addr  = $urandom;
    data_wdata = $urandom;
  endtask

  task automatic check_complete(input vec_t v);
`ifdef SRAMLIKE_AXI_RESP_ERR_EN
    chk("data_err", data_err, (v.resp != 2'b00));
    if (v.resp != 2'b00) sticky_m = 1'b1;
`else
    chk("resp_ignored_ok", data_data_ok, 1);
`endif
  endtask

  task automatic run_txn(input vec_t v);
    bit done, aw_seen, w_seen;
    @(negedge clk);
    axi_quiet();
    data_req = 1'b1; data_wr = v.wr; data_size = v.size;
    data_addr = v.addr; data_wdata = v.wdata;
    #1;
    chk("addr_ok_accept", data_addr_ok, 1);
    chk("data_ok_idle", data_data_ok, 0);
`ifdef SRAMLIKE_AXI_RESP_ERR_EN
    chk("bus_err_sticky", bus_err_sticky, sticky_m);
`endif
    if (!v.wr) begin
      done = 0;
      for (int k = 0; k < 20 && !done; k++) begin
        @(negedge clk);
        axi_quiet(); busy_inputs(v.hold);
        arready = (k >= v.d_a);
        #1;
        chk("arvalid", arvalid, 1);
        chk("araddr", araddr, v.addr);
        chk("awvalid_in_read", awvalid, 0);
        chk("addr_ok_busy", data_addr_ok, 0);
        if (arready) begin
          chk("arsize", arsize, v.exp_axsize);
          done = 1;
        end
      end
      if (!done) timeout("ar_handshake");
      for (int k = 0; k <= v.d_r; k++) begin
        @(negedge clk);
        axi_quiet(); busy_inputs(v.hold);
        rvalid = (k == v.d_r);
        if (rvalid) begin rdata = v.rdata; rresp = v.resp; end
        #1;
        chk("arvalid_after_hs", arvalid, 0);
        chk("rready", rready, 1);
        chk("data_ok_read", data_data_ok, rvalid);
        chk("addr_ok_busy", data_addr_ok, 0);
        if (rvalid) begin
          chk("data_rdata", data_rdata, v.rdata);
          check_complete(v);
        end
      end
    end else begin
      aw_seen = 0; w_seen = 0;
      for (int k = 0; k < 20 && !(aw_seen && w_seen); k++) begin
        @(negedge clk);
        axi_quiet(); busy_inputs(v.hold);
        awready = (k >= v.d_a);
        wready  = (k >= v.d_w);
        #1;
        chk("awvalid", awvalid, !aw_seen);
        chk("wvalid", wvalid, !w_seen);
        chk("bready_early", bready, 0);
        chk("arvalid_in_write", arvalid, 0);
        chk("addr_ok_busy", data_addr_ok, 0);
        if (!aw_seen) begin
          chk("awaddr", awaddr, v.addr);
          chk("awsize", awsize, v.exp_axsize);
        end
        if (!w_seen) begin
          chk("wdata", wdata, v.wdata);
          chk("wstrb", wstrb, v.exp_strb);
        end
        if (awready) aw_seen = 1;
        if (wready)  w_seen  = 1;
      end
      if (!(aw_seen && w_seen)) timeout("aw_w_handshake");
      for (int k = 0; k <= v.d_r; k++) begin
        @(negedge clk);
        axi_quiet(); busy_inputs(v.hold);
        bvalid = (k == v.d_r);
        if (bvalid) bresp = v.resp;
        #1;
        chk("bready", bready, 1);
        chk("awvalid_after_hs", awvalid, 0);
        chk("wvalid_after_hs", wvalid, 0);
        chk("data_ok_write", data_data_ok, bvalid);
        chk("addr_ok_busy", data_addr_ok, 0);
        if (bvalid) check_complete(v);
      end
    end
  endtask

  vec_t dir[8];
  vec_t rv;

  initial begin
    // Directed vectors: expected strobes/sizes written out by hand.
    dir[0] = mk(0, 2'd2, 32'h1000_0004, 32'h0,         32'hDEAD_BEEF, 2'b00, 2, 0, 3, 0, 4'b0000, 3'd2);
    dir[1] = mk(1, 2'd0, 32'h2000_0003, 32'hAB00_0000, 32'h0,         2'b00, 0, 2, 1, 0, 4'b1000, 3'd0);
    dir[2] = mk(1, 2'd1, 32'h2000_0102, 32'h1234_0000, 32'h0,         2'b00, 0, 0, 0, 0, 4'b1100, 3'd1);
    dir[3] = mk(0, 2'd1, 32'h3000_0000, 32'h0,         32'h0000_5A5A, 2'b00, 0, 0, 0, 1, 4'b0000, 3'd1);
    dir[4] = mk(1, 2'd3, 32'h3000_0011, 32'hCAFE_F00D, 32'h0,         2'b00, 1, 1, 2, 1, 4'b1111, 3'd2);
    dir[5] = mk(1, 2'd0, 32'h0000_0040, 32'h0000_0011, 32'h0,         2'b10, 0, 0, 0, 0, 4'b0001, 3'd0);
    dir[6] = mk(0, 2'd2, 32'h0000_0044, 32'h0,         32'h0000_0077, 2'b00, 0, 0, 1, 0, 4'b0000, 3'd2);
    dir[7] = mk(0, 2'd0, 32'h0000_0045, 32'h0,         32'h0000_0055, 2'b11, 1, 0, 0, 0, 4'b0000, 3'd0);

    rst = 1'b1;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'b00; data_addr = '0; data_wdata = '0;
    axi_quiet();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_arvalid", arvalid, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_bready", bready, 0);
    chk("rst_addr_ok", data_addr_ok, 0);
    chk("rst_data_ok", data_data_ok, 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_awaddr", awaddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_arsize", arsize, 0);
    chk("rst_wstrb", wstrb, 4'b0001);
`ifdef SRAMLIKE_AXI_RESP_ERR_EN
    chk("rst_sticky", bus_err_sticky, 0);
`endif

    for (int i = 0; i < 8; i++) run_txn(dir[i]);

    // Random traffic scored against the lane model.
    for (int i = 0; i < 40; i++) begin
      rv.wr    = 1'($urandom);
      rv.size  = 2'($urandom);
      rv.addr  = $urandom;
      rv.wdata = $urandom;
      rv.rdata = $urandom;
      rv.resp  = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      rv.d_a   = $urandom_range(0, 3);
      rv.d_w   = $urandom_range(0, 3);
      rv.d_r   = $urandom_range(0, 3);
      rv.hold  = 1'($urandom);
      rv.exp_strb   = model_strb(rv.size, rv.addr);
      rv.exp_axsize = model_axsize(rv.size);
      run_txn(rv);
      if (!rv.hold && $urandom_range(0, 1) == 1) begin
        @(negedge clk);
        axi_quiet(); data_req = 1'b0;
        #1;
        chk("gap_addr_ok", data_addr_ok, 0);
        chk("gap_data_ok", data_data_ok, 0);
      end
    end

    // Asynchronous reset while waiting for read data.
    @(negedge clk);
    axi_quiet();
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h5000_0000;
    #1;
    chk("rstmid_accept", data_addr_ok, 1);
    @(negedge clk);
    axi_quiet(); data_req = 1'b0; arready = 1'b1;
    #1;
    chk("rstmid_arvalid", arvalid, 1);
    @(negedge clk);
    axi_quiet(); rvalid = 1'b1; rdata = 32'h1111_2222;
    #1;
    chk("rstmid_rready", rready, 1);
    chk("rstmid_data_ok_pre", data_data_ok, 1);
    #1 rst = 1'b1;
    #1;
    chk("rstmid_rready_low", rready, 0);
    chk("rstmid_arvalid_low", arvalid, 0);
    chk("rstmid_data_ok_low", data_data_ok, 0);
    chk("rstmid_awvalid_low", awvalid, 0);
    sticky_m = 1'b0;
    @(negedge clk);
    rst = 1'b0; axi_quiet();
    #1;
    chk("rstmid_idle_rready", rready, 0);
    chk("rstmid_idle_arvalid", arvalid, 0);
`ifdef SRAMLIKE_AXI_RESP_ERR_EN
    chk("rstmid_sticky_clear", bus_err_sticky, 0);
`endif
    run_txn(mk(0, 2'd2, 32'h6000_0008, 32'h0, 32'h8765_4321, 2'b00, 1, 0, 1, 0, 4'b0000, 3'd2));
    run_txn(mk(1, 2'd1, 32'h6000_0000, 32'h0000_BEEF, 32'h0, 2'b00, 2, 0, 0, 0, 4'b0011, 3'd1));

    @(negedge clk);
    data_req = 1'b0; axi_quiet();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sramlike_axi_bridge.md
Name: sramlike_axi_bridge

Overview:
- Responder for the cache-side sram-like data port.
- Accepts one cache_data_* style request at a time and issues it as a single-beat AXI transaction: AR/R for reads, AW/W/B for writes.
- Returns addr_ok/data_ok in the same sram-like protocol the data cache drives.
- Sits between d-cache and the top-level AXI wrapper. The wrapper ties AXI id/len/burst/cache/prot/wlast constants.

Parameters:
ADDR_W, 32, address width on both sides
DATA_W, 32, data width (fixed to 32; WSTRB is 4 bits)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
data_req  in  1  sram-like request
data_wr  in  1  1 = write
data_size  in  2  0 byte, 1 half, 2 word
data_addr  in  32  byte address
data_wdata  in  32  write data, lane-aligned
data_rdata  out  32  read data, valid with data_ok
data_addr_ok  out  1  request accepted
data_data_ok  out  1  transaction complete
araddr  out  32  read address
arsize  out  3  {1'b0,size}
arvalid  out  1  AR valid
arready  in  1  AR ready
rdata  in  32  read data
rresp  in  2  read response
rvalid  in  1  R valid
rready  out  1  R ready
awaddr  out  32  write address
awsize  out  3  {1'b0,size}
awvalid  out  1  AW valid
awready  in  1  AW ready
wdata  out  32  write data
wstrb  out  4  byte strobes
wvalid  out  1  W valid
wready  in  1  W ready
bresp  in  2  write response
bvalid  in  1  B valid
bready  out  1  B ready

Behaviour:
- Reset: state IDLE; all valids, rready, bready, addr_ok, data_ok are 0. Latched request regs are 0.
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP.
- IDLE:
  - data_addr_ok = data_req, combinational.
  - On req: latch wr, size, addr, wdata.
  - Next state is RD_ADDR if ~wr, else WR_REQ.
- RD_ADDR: arvalid=1 with latched addr/size; on arvalid&arready -> RD_DATA.
- RD_DATA: rready=1.
  - On rvalid: data_data_ok=1 and data_rdata=rdata, both combinational in the same cycle.
  - Next state IDLE.
- WR_REQ:
  - awvalid and wvalid are asserted together.
  - Flags aw_done/w_done drop each valid independently after its handshake.
  - Both handshakes may occur in the same cycle or in either order.
  - When both are done -> WR_RESP.
- WR_RESP: bready=1; on bvalid: data_data_ok=1, next state IDLE.
- addr_ok is never asserted outside IDLE. Earliest back-to-back accept is the cycle after data_ok, so there is at most one outstanding transaction.
- data_rdata outside data_ok is don't-care (drives rdata).
- wstrb:
  - size 0 -> 4'b0001 << addr[1:0].
  - size 1 -> addr[1] ? 4'b1100 : 4'b0011.
  - size 2 or 3 -> 4'b1111.
  - Size 3 is treated as word on AXI, with arsize/awsize = 3'b010.
- Addresses are passed unmodified; no alignment masking.
- Valid signals, once raised, stay stable until their handshake (AXI rule). Latched fields do not change while not in IDLE.
- Async rst mid-transaction: immediate return to IDLE with all valids low. The AXI slave is reset on the same rst.
- Nonzero rresp/bresp still completes the transaction normally.

Optional Feature:
- Macro: SRAMLIKE_AXI_RESP_ERR_EN.
- Defined:
  - Adds output data_err (1 bit).
  - Asserted with data_data_ok when the completing rresp/bresp is nonzero (SLVERR/DECERR).
  - Also sets a sticky internal err_seen, readable via output bus_err_sticky, cleared only by rst.
- Undefined: neither port exists; responses are ignored.

Decomposition:
- Shared package sramlike_axi_pkg:
  - State enum.
  - SIZE_BYTE/HALF/WORD constants.
  - AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR.
- Sub-module axi_wstrb_gen: combinational size+addr[1:0] -> wstrb. Reused by future instruction/uncached bridges.

Test Plan:
1. Read word: req addr 0x1000_0004 size 2, arready=1 after 2 cycles, rvalid with 0xDEADBEEF 3 cycles later -> addr_ok in cycle 0, araddr=0x1000_0004, arsize=3'b010, data_ok 1 cycle with data_rdata=0xDEADBEEF.
2. Byte write: addr 0x...0003 size 0, wdata 0xAB00_0000; awready before wready by 2 cycles -> wstrb=4'b1000, awvalid drops first, bready only after both handshakes, data_ok on bvalid.
3. Same-cycle AW/W: awready=wready=1 in the same cycle -> WR_RESP next cycle; half write at addr[1]=1 gives wstrb=4'b1100.
4. Back-to-back: req held high continuously (read then write) -> second addr_ok exactly one cycle after first data_ok; no overlap of arvalid and awvalid.
5. Reset mid RD_DATA: assert rst asynchronously mid-cycle -> arvalid/rready/data_ok low immediately, IDLE after release, next req accepted.
6. With SRAMLIKE_AXI_RESP_ERR_EN: bresp=2'b10 -> data_err=1 with data_ok, bus_err_sticky stays 1 through a later OKAY read until rst.
